// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave control FSM.
// The state set gains RD_INC/WR_INC when SPI_CTRL_BURST_EN is defined.
package spi_pkg;

   localparam int unsigned SPI_ADDR_WIDTH = 7;
   localparam int unsigned SPI_DATA_WIDTH = 8;

`ifdef SPI_CTRL_BURST_EN
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DECODE,
      ST_RD_LOAD,
      ST_READ,
      ST_WRITE,
      ST_WR_COMMIT,
      ST_DONE,
      ST_RD_INC,
      ST_WR_INC
   } spi_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DECODE,
      ST_RD_LOAD,
      ST_READ,
      ST_WRITE,
      ST_WR_COMMIT,
      ST_DONE
   } spi_state_e;
`endif

   // Wide enough to hold the longest phase length without wrapping.
   function automatic int unsigned spi_cnt_width(input int unsigned aw, input int unsigned dw);
      int unsigned m;
      m = (aw > dw) ? aw : dw;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Serial bit counter shared by the address and data phases.
// Clear has priority over enable; tc_o flags count == limit_i.
module spi_bit_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/spi_ctrl_fsm.sv
// SPI slave control FSM: address latch, shift-register load, memory write, MISO enable.
// Define SPI_CTRL_BURST_EN for multi-word bursts with address auto-increment.
module spi_ctrl_fsm
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SPI_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk_edge,
   input  logic cs,
   input  logic rw,
   output logic miso_buff,
   output logic dm_we,
   output logic addr_we,
   output logic sr_we,
   output logic addr_inc,
   output logic xfer_done
);

   localparam int unsigned CNT_W = spi_cnt_width(ADDR_WIDTH, DATA_WIDTH);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   spi_state_e state_q, state_d;
   logic       miso_buff_q, miso_buff_d;
   logic       dm_we_q, dm_we_d;
   logic       addr_we_q, addr_we_d;
   logic       sr_we_q, sr_we_d;
   logic       xfer_done_q, xfer_done_d;
`ifdef SPI_CTRL_BURST_EN
   logic       addr_inc_q, addr_inc_d;
`endif

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_limit;

   assign cnt_limit = (state_q == ST_ADDR) ? ADDR_LAST : DATA_LAST;

   spi_bit_counter #(
      .WIDTH(CNT_W)
   ) u_bit_counter (
      .clk_i    (clk),
      .reset_i  (reset),
      .clear_i  (cnt_clr),
      .enable_i (cnt_en),
      .limit_i  (cnt_limit),
      .tc_o     (cnt_tc)
   );

   always_comb begin
      state_d     = state_q;
      miso_buff_d = 1'b0;
      dm_we_d     = 1'b0;
      addr_we_d   = 1'b0;
      sr_we_d     = 1'b0;
      xfer_done_d = 1'b0;
`ifdef SPI_CTRL_BURST_EN
      addr_inc_d  = 1'b0;
`endif
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (sclk_edge) begin
               state_d   = ST_ADDR;
               addr_we_d = 1'b1;
               cnt_clr   = 1'b1;
            end
         end
         ST_ADDR: begin
            addr_we_d = 1'b1;
            if (sclk_edge) begin
               if (cnt_tc) begin
                  addr_we_d = 1'b0;
                  cnt_clr   = 1'b1;
                  state_d   = ST_DECODE;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         ST_DECODE: begin
            if (sclk_edge) begin
               if (rw) begin
                  state_d = ST_RD_LOAD;
                  sr_we_d = 1'b1;
               end else begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_RD_LOAD: begin
            state_d     = ST_READ;
            miso_buff_d = 1'b1;
         end
         ST_READ: begin
            miso_buff_d = 1'b1;
            if (sclk_edge) begin
               if (cnt_tc) begin
                  cnt_clr     = 1'b1;
                  xfer_done_d = 1'b1;
`ifdef SPI_CTRL_BURST_EN
                  state_d     = ST_RD_INC;
                  addr_inc_d  = 1'b1;
`else
                  state_d     = ST_DONE;
                  miso_buff_d = 1'b0;
`endif
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            if (sclk_edge) begin
               if (cnt_tc) begin
                  cnt_clr     = 1'b1;
                  state_d     = ST_WR_COMMIT;
                  dm_we_d     = 1'b1;
                  xfer_done_d = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         ST_WR_COMMIT: begin
`ifdef SPI_CTRL_BURST_EN
            state_d    = ST_WR_INC;
            addr_inc_d = 1'b1;
`else
            state_d    = ST_DONE;
`endif
         end
`ifdef SPI_CTRL_BURST_EN
         ST_RD_INC: begin
            state_d     = ST_RD_LOAD;
            sr_we_d     = 1'b1;
            miso_buff_d = 1'b1;
         end
         ST_WR_INC: begin
            state_d = ST_WRITE;
         end
`endif
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Deselect overrides every state decision, including a coincident edge.
      if (cs) begin
         state_d     = ST_IDLE;
         miso_buff_d = 1'b0;
         dm_we_d     = 1'b0;
         addr_we_d   = 1'b0;
         sr_we_d     = 1'b0;
         xfer_done_d = 1'b0;
`ifdef SPI_CTRL_BURST_EN
         addr_inc_d  = 1'b0;
`endif
         cnt_clr     = 1'b1;
         cnt_en      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         miso_buff_q <= 1'b0;
         dm_we_q     <= 1'b0;
         addr_we_q   <= 1'b0;
         sr_we_q     <= 1'b0;
         xfer_done_q <= 1'b0;
`ifdef SPI_CTRL_BURST_EN
         addr_inc_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         miso_buff_q <= miso_buff_d;
         dm_we_q     <= dm_we_d;
         addr_we_q   <= addr_we_d;
         sr_we_q     <= sr_we_d;
         xfer_done_q <= xfer_done_d;
`ifdef SPI_CTRL_BURST_EN
         addr_inc_q  <= addr_inc_d;
`endif
      end
   end

   assign miso_buff = miso_buff_q;
   assign dm_we     = dm_we_q;
   assign addr_we   = addr_we_q;
   assign sr_we     = sr_we_q;
   assign xfer_done = xfer_done_q;
`ifdef SPI_CTRL_BURST_EN
   assign addr_inc  = addr_inc_q;
`else
   assign addr_inc  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ctrl_fsm.sv
// Self-checking bench for spi_ctrl_fsm: default (7/8) and 4/16 instances share one stimulus stream.
// Expected waveforms are derived per frame from the edge timeline; honours SPI_CTRL_BURST_EN.
module tb_spi_ctrl_fsm;

`ifdef SPI_CTRL_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam int MAXT = 512;

   // Output vector bit positions.
   localparam int B_MISO = 5;
   localparam int B_DM   = 4;
   localparam int B_ADDR = 3;
   localparam int B_SR   = 2;
   localparam int B_INC  = 1;
   localparam int B_DONE = 0;

   logic clk = 1'b0;
   logic reset, sclk_edge, cs, rw;
   logic miso0, dm0, awe0, sr0, inc0, done0;
   logic miso1, dm1, awe1, sr1, inc1, done1;

   always #5 clk = ~clk;

   spi_ctrl_fsm u_dut_def (
      .clk       (clk),
      .reset     (reset),
      .sclk_edge (sclk_edge),
      .cs        (cs),
      .rw        (rw),
      .miso_buff (miso0),
      .dm_we     (dm0),
      .addr_we   (awe0),
      .sr_we     (sr0),
      .addr_inc  (inc0),
      .xfer_done (done0)
   );

   spi_ctrl_fsm #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(16)
   ) u_dut_wide (
      .clk       (clk),
      .reset     (reset),
      .sclk_edge (sclk_edge),
      .cs        (cs),
      .rw        (rw),
      .miso_buff (miso1),
      .dm_we     (dm1),
      .addr_we   (awe1),
      .sr_we     (sr1),
      .addr_inc  (inc1),
      .xfer_done (done1)
   );

   logic cs_a   [MAXT];
   logic edge_a [MAXT];
   logic rw_a   [MAXT];
   logic rst_a  [MAXT];
   logic [5:0] exp_a [2][MAXT+1];
   int   frame_len;
   int   frame_id = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (miso,dm_we,addr_we,sr_we,addr_inc,xfer_done)",
                  tag, got, exp);
      end
   endtask

   // Frame: cs high 2 cycles, then cs low with n_edges edges spaced 3..5 clocks.
   // rst_edge >= 0 asserts reset coincident with that edge; cs_delay < 0 raises cs on the last edge.
   task automatic build_frame(input int n_edges, input bit rw_v, input int rst_edge, input int cs_delay);
      int t;
      int g;
      bit was_reset;
      for (int i = 0; i < MAXT; i++) begin
         cs_a[i]   = 1'b1;
         edge_a[i] = 1'b0;
         rw_a[i]   = 1'($urandom_range(0, 1));
         rst_a[i]  = 1'b0;
      end
      t = 2;
      was_reset = 1'b0;
      for (int i = 0; i < n_edges; i++) begin
         g = $urandom_range(3, 5);
         for (int j = 0; j < g - 1; j++) begin
            cs_a[t] = 1'b0;
            t++;
         end
         cs_a[t]   = 1'b0;
         edge_a[t] = 1'b1;
         rw_a[t]   = rw_v;
         if (i == rst_edge) begin
            rst_a[t]  = 1'b1;
            was_reset = 1'b1;
            t++;
            break;
         end
         t++;
      end
      if (!was_reset) begin
         if (cs_delay < 0) begin
            cs_a[t-1] = 1'b1;
         end else begin
            for (int j = 0; j < cs_delay; j++) begin
               cs_a[t] = 1'b0;
               t++;
            end
         end
      end
      frame_len = t + 3;
   endtask

   task automatic mark(input int di, input int t, input int c, input int b);
      if (t <= c && t <= frame_len) exp_a[di][t][b] = 1'b1;
   endtask

   // Expected outputs from the edge timeline: edge k of a frame is numbered from the
   // start edge; address edges 1..aw, rw edge aw+1, then dw-edge data words.
   task automatic compute_exp(input int di, input int aw, input int dw);
      int c, k, d, nw, last, miso_end;
      int ev [MAXT];
      bit rd;
      c = frame_len;
      for (int t = 2; t < frame_len; t++) begin
         if (cs_a[t] || rst_a[t]) begin
            c = t;
            break;
         end
      end
      for (int t = 0; t <= frame_len; t++) exp_a[di][t] = '0;
      k = 0;
      for (int t = 2; t < c; t++) begin
         if (edge_a[t]) begin
            ev[k] = t;
            k++;
         end
      end
      if (k > 0) begin
         last = (k > aw) ? ev[aw] : c;
         for (int t = ev[0] + 1; t <= last; t++) mark(di, t, c, B_ADDR);
      end
      if (k > aw + 1) begin
         d  = ev[aw+1];
         rd = rw_a[d];
         nw = (k - (aw + 2)) / dw;
         if (!BURST && nw > 1) nw = 1;
         for (int w = 0; w < nw; w++) begin
            last = ev[aw + 1 + (w + 1) * dw];
            mark(di, last + 1, c, B_DONE);
            if (!rd) begin
               mark(di, last + 1, c, B_DM);
               if (BURST) mark(di, last + 2, c, B_INC);
            end else if (BURST) begin
               mark(di, last + 1, c, B_INC);
               mark(di, last + 2, c, B_SR);
            end
         end
         if (rd) begin
            mark(di, d + 1, c, B_SR);
            miso_end = (BURST || nw == 0) ? c : ev[aw + 1 + dw];
            for (int t = d + 2; t <= miso_end; t++) mark(di, t, c, B_MISO);
         end
      end
   endtask

   task automatic play_frame();
      compute_exp(0, 7, 8);
      compute_exp(1, 4, 16);
      for (int t = 0; t <= frame_len; t++) begin
         @(posedge clk);
         #1;
         check_eq($sformatf("frame%0d def t%0d", frame_id, t),
                  {miso0, dm0, awe0, sr0, inc0, done0}, exp_a[0][t]);
         check_eq($sformatf("frame%0d wide t%0d", frame_id, t),
                  {miso1, dm1, awe1, sr1, inc1, done1}, exp_a[1][t]);
         if (t < frame_len) begin
            reset     = rst_a[t];
            cs        = cs_a[t];
            sclk_edge = edge_a[t];
            rw        = rw_a[t];
         end else begin
            reset     = 1'b0;
            cs        = 1'b1;
            sclk_edge = 1'b0;
         end
      end
      frame_id++;
   endtask

   task automatic run_frame(input int n_edges, input bit rw_v, input int rst_edge, input int cs_delay);
      build_frame(n_edges, rw_v, rst_edge, cs_delay);
      play_frame();
   endtask

   initial begin
      int n, base, rst_e, csd;
      // Reset dominates a selected bus with an edge present.
      reset     = 1'b1;
      cs        = 1'b0;
      sclk_edge = 1'b1;
      rw        = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("reset def",  {miso0, dm0, awe0, sr0, inc0, done0}, 6'b000000);
         check_eq("reset wide", {miso1, dm1, awe1, sr1, inc1, done1}, 6'b000000);
      end
      reset     = 1'b0;
      cs        = 1'b1;
      sclk_edge = 1'b0;

      run_frame(17, 1'b0, -1, 2);   // full write, default widths
      run_frame(17, 1'b1, -1, 3);   // full read, default widths
      run_frame(22, 1'b0, -1, 2);   // full write for the 4/16 instance
      run_frame(14, 1'b0, -1, 1);   // abort after 5th data edge (default)
      run_frame(14, 1'b1, 12, 0);   // reset coincident with a read data edge
      run_frame(17, 1'b0, -1, -1);  // cs rises on the last data edge
      run_frame(33, 1'b0, -1, 2);   // three-word write frame
      run_frame(33, 1'b1, -1, 2);   // three-word read frame
      run_frame(54, 1'b0, -1, 3);   // three-word write for the 4/16 instance

      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 4) == 0) begin
            n = $urandom_range(1, 20);
         end else begin
            base = ($urandom_range(0, 1) == 1) ? (6 + 16 * $urandom_range(1, 3))
                                               : (9 + 8 * $urandom_range(1, 3));
            n = base + $urandom_range(0, 4) - 2;
         end
         rst_e = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
         csd   = $urandom_range(0, 5) - 1;
         run_frame(n, 1'($urandom_range(0, 1)), rst_e, csd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
